// File: rtl/instr_encoder_loader.sv
// Packs decoded RV32I-subset fields into instruction words and writes them
// sequentially into instruction memory over a registered write port.
module instr_encoder_loader #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     finish,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_class,
    input  logic [1:0]               in_op,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_rs1,
    input  logic [4:0]               in_rs2,
    input  logic [11:0]              in_imm,
    output logic                     imem_we,
    output logic [31:0]              imem_addr,
    output logic [31:0]              imem_wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     done,
    output logic                     err
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic          beat_ok;
    logic [2:0]    alu_f3;
    logic [31:0]   word;
    logic          accept;
    logic          write;
    logic [CW-1:0] count_next;
    logic          err_next;
    logic          done_next;

    // count already includes the word currently on the write port, so no
    // separate pending term is needed for the full check
    assign in_ready = (state == LOAD) && (count < CW'(DEPTH)) && !start;
    assign accept   = in_valid && in_ready;
    assign write    = accept && beat_ok;

    // Field legality and instruction packing
    always_comb begin
        beat_ok = 1'b0;
        word    = 32'h0;
        case (in_op)
            2'b10:   alu_f3 = 3'b111;
            2'b11:   alu_f3 = 3'b110;
            default: alu_f3 = 3'b000;
        endcase
        case (in_class)
            3'b000: begin
                beat_ok = 1'b1;
                word    = {(in_op == 2'b01) ? 7'b0100000 : 7'b0000000,
                           in_rs2, in_rs1, alu_f3, in_rd, 7'b0110011};
            end
            3'b001: begin
                beat_ok = (in_op != 2'b01);
                word    = {in_imm, in_rs1, alu_f3, in_rd, 7'b0010011};
            end
            3'b010: begin
                beat_ok = (in_op == 2'b00);
                word    = {in_imm, in_rs1, 3'b010, in_rd, 7'b0000011};
            end
            3'b011: begin
                beat_ok = (in_op == 2'b00);
                word    = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
            end
            3'b100: begin
                beat_ok = !in_op[1];
                word    = {in_imm[11], in_imm[9:4], in_rs2, in_rs1, 2'b00, in_op[0],
                           in_imm[3:0], in_imm[10], 7'b1100011};
            end
            default: ;
        endcase
    end

    // Session control and next values for the registered outputs
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    if (start) state_next = LOAD;
                     else if (finish) state_next = DONE;
            DONE:    if (start) state_next = LOAD;
            default: state_next = IDLE;
        endcase

        count_next = count;
        err_next   = err;
        if (start) begin
            count_next = '0;
            err_next   = 1'b0;
        end else begin
            if (write)              count_next = count + CW'(1);
            if (accept && !beat_ok) err_next   = 1'b1;
        end

        // a write still draining at close delays done by one cycle
        done_next = (state_next == DONE) && !write;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= 32'h0;
            imem_wdata <= 32'h0;
            count      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state   <= state_next;
            imem_we <= write;
            if (write) begin
                imem_addr  <= BASE_ADDR + (32'(count) << 2);
                imem_wdata <= word;
            end
            count <= count_next;
            done  <= done_next;
            err   <= err_next;
        end
    end

endmodule
